// File: rtl/uart_alu_pkg.sv
// Shared constants for the UART/ALU command path: framer state codes, default widths and the
// opcode encodings understood by the ALU.
package uart_alu_pkg;

  localparam int unsigned NB_DATA_DEFAULT   = 8;
  localparam int unsigned NB_OPCODE_DEFAULT = 6;

  localparam int unsigned NB_STATE = 3;
  localparam logic [NB_STATE-1:0] ST_WAIT_A  = 3'd0;
  localparam logic [NB_STATE-1:0] ST_WAIT_B  = 3'd1;
  localparam logic [NB_STATE-1:0] ST_WAIT_OP = 3'd2;
  localparam logic [NB_STATE-1:0] ST_LOAD    = 3'd3;
  localparam logic [NB_STATE-1:0] ST_WAIT_TX = 3'd4;

  localparam logic [NB_OPCODE_DEFAULT-1:0] OP_ADD = 6'h20;
  localparam logic [NB_OPCODE_DEFAULT-1:0] OP_SUB = 6'h22;
  localparam logic [NB_OPCODE_DEFAULT-1:0] OP_AND = 6'h24;
  localparam logic [NB_OPCODE_DEFAULT-1:0] OP_OR  = 6'h25;
  localparam logic [NB_OPCODE_DEFAULT-1:0] OP_XOR = 6'h26;
  localparam logic [NB_OPCODE_DEFAULT-1:0] OP_SRA = 6'h03;
  localparam logic [NB_OPCODE_DEFAULT-1:0] OP_SRL = 6'h02;
  localparam logic [NB_OPCODE_DEFAULT-1:0] OP_NOR = 6'h27;

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector on a level input; the delay flop's reset value is configurable so a
// level already high at reset release can be suppressed.
module edge_detect_rise #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_level,
  output logic o_pulse
);

  logic level_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      level_d <= RESET_VALUE;
    end else begin
      level_d <= i_level;
    end
  end

  assign o_pulse = i_level & ~level_d;

endmodule

// File: rtl/uart_alu_interface.sv
// Frames three received bytes (A, B, opcode) for the ALU and hands the result to the UART
// transmitter. Optional inter-byte timeout is built when UART_ALU_IF_TIMEOUT_EN is defined.
module uart_alu_interface
  import uart_alu_pkg::*;
#(
  parameter int unsigned NB_DATA    = NB_DATA_DEFAULT,
  parameter int unsigned NB_OPCODE  = NB_OPCODE_DEFAULT,
  parameter int unsigned NB_TIMEOUT = 24,
  parameter logic [NB_TIMEOUT-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NB_DATA-1:0]   i_rx_data,
  input  logic                 i_rx_done,
  input  logic [NB_DATA-1:0]   i_alu_result,
  input  logic                 i_tx_done,
  output logic [NB_DATA-1:0]   o_data_a,
  output logic [NB_DATA-1:0]   o_data_b,
  output logic [NB_OPCODE-1:0] o_opcode,
  output logic [NB_DATA-1:0]   o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy
);

  logic                rx_evt;
  logic                tx_evt;
  logic                timeout;
  logic [NB_STATE-1:0] state;
  logic [NB_STATE-1:0] state_next;

  edge_detect_rise #(
    .RESET_VALUE(1'b1)
  ) u_rx_edge (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_level(i_rx_done),
    .o_pulse(rx_evt)
  );

  edge_detect_rise #(
    .RESET_VALUE(1'b1)
  ) u_tx_edge (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_level(i_tx_done),
    .o_pulse(tx_evt)
  );

`ifdef UART_ALU_IF_TIMEOUT_EN
  logic [NB_TIMEOUT-1:0] timeout_cnt;
  logic                  mid_command;

  assign mid_command = (state == ST_WAIT_B) || (state == ST_WAIT_OP);

  // Held at zero outside the partial-command states, which also covers entry to ST_WAIT_A.
  always_ff @(posedge i_clock) begin
    if (i_reset || rx_evt || !mid_command) begin
      timeout_cnt <= '0;
    end else begin
      timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

  assign timeout = mid_command && (timeout_cnt == TIMEOUT_CYCLES - 1'b1);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, NB_TIMEOUT};
  assign timeout = 1'b0;
`endif

  // rx_evt has priority over timeout so a byte landing on the expiry cycle is kept.
  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT_A:  if (rx_evt) state_next = ST_WAIT_B;
      ST_WAIT_B: begin
        if (rx_evt)       state_next = ST_WAIT_OP;
        else if (timeout) state_next = ST_WAIT_A;
      end
      ST_WAIT_OP: begin
        if (rx_evt)       state_next = ST_LOAD;
        else if (timeout) state_next = ST_WAIT_A;
      end
      ST_LOAD:    state_next = ST_WAIT_TX;
      ST_WAIT_TX: if (tx_evt) state_next = ST_WAIT_A;
      default:    state_next = ST_WAIT_A;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= ST_WAIT_A;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_opcode   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
    end else begin
      state      <= state_next;
      o_tx_start <= (state == ST_LOAD);
      if (state == ST_WAIT_A && rx_evt)  o_data_a  <= i_rx_data;
      if (state == ST_WAIT_B && rx_evt)  o_data_b  <= i_rx_data;
      if (state == ST_WAIT_OP && rx_evt) o_opcode  <= i_rx_data[NB_OPCODE-1:0];
      if (state == ST_LOAD)              o_tx_data <= i_alu_result;
    end
  end

  assign o_busy = (state == ST_LOAD) || (state == ST_WAIT_TX);

endmodule

// File: doc/uart_alu_interface.md
# uart_alu_interface

Command framer between the UART receiver and the ALU/transmitter pair. Collects three consecutive received bytes (operand A, operand B, opcode) from the receiver's `done` strobe and presents them as stable registers to the combinational ALU. Latches the ALU result and hands it to the UART transmitter with a one-cycle start pulse, then waits for transmit completion before accepting the next command.

## Interface
Parameters:
- `NB_DATA`, 8: width of received byte, operands and result.
- `NB_OPCODE`, 6: opcode width; the low `NB_OPCODE` bits of the third byte.
- `NB_TIMEOUT`, 24: inter-byte timeout counter width. Used only with the timeout feature.
- `TIMEOUT_CYCLES`, 24'd10_000_000: inter-byte timeout in `i_clock` cycles. Used only with the timeout feature.

Ports:
- Clock and reset: `i_reset` is synchronous, active-high; the clock is `i_clock`.
- `i_clock` in 1: system clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_rx_data` in `NB_DATA`: received byte. Valid while `i_rx_done` is high.
- `i_rx_done` in 1: receiver done level. May stay high for many clocks.
- `i_alu_result` in `NB_DATA`: combinational ALU output.
- `i_tx_done` in 1: transmitter done level. May stay high for many clocks.
- `o_data_a` out `NB_DATA`: operand A register.
- `o_data_b` out `NB_DATA`: operand B register.
- `o_opcode` out `NB_OPCODE`: opcode register.
- `o_tx_data` out `NB_DATA`: result byte to the transmitter.
- `o_tx_start` out 1: one-cycle transmit request.
- `o_busy` out 1: high from opcode capture until the transmit completes.

## Operation
- Edge detection:
  - `rx_evt = i_rx_done & ~rx_done_d`.
  - `tx_evt = i_tx_done & ~tx_done_d`.
  - Both delay registers reset to 1, so a level held high through reset produces no event.
- FSM states:
  - `ST_WAIT_A`: on `rx_evt`, load `o_data_a`, go to `ST_WAIT_B`.
  - `ST_WAIT_B`: on `rx_evt`, load `o_data_b`, go to `ST_WAIT_OP`.
  - `ST_WAIT_OP`: on `rx_evt`, load `o_opcode` from `i_rx_data[NB_OPCODE-1:0]` (upper bits discarded), go to `ST_LOAD`.
  - `ST_LOAD`: unconditionally latch `i_alu_result` into `o_tx_data`, assert `o_tx_start` (registered), go to `ST_WAIT_TX`.
  - `ST_WAIT_TX`: on `tx_evt`, go to `ST_WAIT_A`.
- `rx_evt` in `ST_LOAD` or `ST_WAIT_TX` is ignored; that byte is lost. Operand and opcode registers are never modified outside their own capture state.
- `tx_evt` outside `ST_WAIT_TX` is ignored.
- Operand, opcode and `o_tx_data` registers hold their value until overwritten. They are not cleared between commands.
- Reset in any state: return to `ST_WAIT_A`. All outputs go to 0 on the next edge, including a `o_tx_start` pulse in flight.

## Timing
- `rx_evt` seen in cycle n: the captured register is visible in cycle n+1.
- Opcode `rx_evt` in cycle n:
  - state is `ST_LOAD` in n+1;
  - `o_tx_start`=1 and `o_tx_data` is valid in n+2, for exactly one cycle.
- `o_busy` is high from n+1 until the cycle after `tx_evt`.
- `tx_evt` in cycle m: state is `ST_WAIT_A` in m+1. An `rx_evt` in m+1 is accepted as operand A.
- The ALU is combinational and must settle within one cycle of `o_opcode` update.

## Configuration
- `UART_ALU_IF_TIMEOUT_EN` defined:
  - A `NB_TIMEOUT`-bit counter clears on every `rx_evt` and on entry to `ST_WAIT_A`.
  - It increments each cycle in `ST_WAIT_B` and `ST_WAIT_OP`.
  - When it reaches `TIMEOUT_CYCLES-1`, the FSM returns to `ST_WAIT_A` on the next edge without touching any output register.
  - If `rx_evt` arrives in the same cycle as the timeout, `rx_evt` wins: the byte is captured and the counter clears.
- `UART_ALU_IF_TIMEOUT_EN` undefined: no counter is built, and a partial command waits indefinitely.

## Structure
- Shared package `uart_alu_pkg` holds:
  - the state encoding localparams (`NB_STATE`=3 and the five state codes);
  - the default `NB_DATA` and `NB_OPCODE`;
  - the opcode constants shared with the ALU (ADD, SUB, AND, OR, XOR, SRA, SRL, NOR).
- One sub-module, `edge_detect_rise`: a parameterised reset value on the delay flop and a rising-edge pulse output. It is instantiated twice, for rx and tx.

## Test plan
- Bytes 0x05, 0x03, 0x20 (ADD), each with `i_rx_done` held high 16 clocks:
  - `o_data_a`=0x05, `o_data_b`=0x03, `o_opcode`=0x20;
  - one `o_tx_start` pulse with `o_tx_data`=0x08, two cycles after the opcode edge.
- `i_rx_done` held high across reset release, then a command sends 0xFF, 0x01, 0x22 (SUB):
  - no capture while the level is held;
  - `o_tx_data`=0xFE.
- A byte 0x77 arrives during `ST_WAIT_TX`:
  - it is ignored;
  - after `tx_evt`, the next bytes 0x0F, 0xF0, 0x25 (OR) give `o_tx_data`=0xFF.
- Reset asserted in `ST_WAIT_OP` after A=0x10, B=0x20:
  - all outputs are 0;
  - the next three bytes are treated as A, B, opcode.
- With `UART_ALU_IF_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100:
  - send A=0x11, then idle 100 cycles → state `ST_WAIT_A`;
  - a byte at cycle 99 instead is captured as B.
- Opcode byte 0xE4 → `o_opcode`=0x24; `o_busy` stays high until the first `tx_evt`.
